// File: rtl/vdac_seq_ctrl.sv
// Sequencer for the voltage DAC: static, sawtooth, triangle and SAR search modes.
// All step and trial timing derives from a shared prescaler with live terminal count i_div.
module vdac_seq_ctrl #(
  parameter int unsigned BITWIDTH = 6,
  parameter int unsigned DIVW     = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [1:0]          i_mode,
  input  logic [BITWIDTH-1:0] i_code,
  input  logic [DIVW-1:0]     i_div,
  input  logic                i_cmp,
  output logic [BITWIDTH-1:0] o_dac_data,
  output logic                o_dac_enable,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_wrap,
  output logic [BITWIDTH-1:0] o_result
);

  // Two extra counter bits so a SAR trial of i_div+3 cycles fits at i_div = max.
  localparam int unsigned CW = DIVW + 2;

  localparam logic [BITWIDTH-1:0] CodeMax = {BITWIDTH{1'b1}};
  localparam logic [BITWIDTH-1:0] CodeOne = {{(BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [BITWIDTH-1:0] CodeMsb = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StSar} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BITWIDTH-1:0] code_q, code_d;
  logic                dir_up_q, dir_up_d;
  logic [BITWIDTH-1:0] sar_bit_q, sar_bit_d;
  logic [BITWIDTH-1:0] result_q, result_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;
  logic                cmp_meta_q, cmp_sync_q;

  logic [CW-1:0]       run_term;
  logic [CW-1:0]       sar_term;
  logic                tick;
  logic                trial_end;
  logic [BITWIDTH-1:0] sar_code;

  always_comb begin
    run_term  = CW'(i_div);
    sar_term  = CW'(i_div) + CW'(2);
    tick      = (cnt_q == run_term);
    trial_end = (cnt_q == sar_term);
    sar_code  = code_q;

    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    dir_up_d  = dir_up_q;
    sar_bit_d = sar_bit_q;
    result_d  = result_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          mode_d   = i_mode;
          cnt_d    = '0;
          dir_up_d = 1'b1;
          if (i_mode == 2'd3) begin
            state_d   = StSar;
            code_d    = CodeMsb;
            sar_bit_d = CodeMsb;
          end else begin
            state_d = StRun;
            code_d  = (i_mode == 2'd0) ? i_code : '0;
          end
        end
      end

      StRun: begin
        if (i_stop) begin
          state_d = StIdle;
        end else begin
          cnt_d = tick ? '0 : cnt_q + CW'(1);
          if (tick) begin
            case (mode_q)
              2'd0: code_d = i_code;
              2'd1: begin
                code_d = code_q + CodeOne;
                wrap_d = (code_q == CodeMax);
              end
              default: begin
                if (dir_up_q) begin
                  if (code_q == CodeMax) begin
                    code_d   = code_q - CodeOne;
                    dir_up_d = 1'b0;
                  end else begin
                    code_d = code_q + CodeOne;
                  end
                end else begin
                  code_d = code_q - CodeOne;
                  // Turning at 0 marks the end of the triangle period.
                  if (code_q == CodeOne) begin
                    dir_up_d = 1'b1;
                    wrap_d   = 1'b1;
                  end
                end
              end
            endcase
          end
        end
      end

      StSar: begin
        if (i_stop) begin
          state_d = StIdle;
        end else begin
          cnt_d = trial_end ? '0 : cnt_q + CW'(1);
          if (trial_end) begin
            if (cmp_sync_q) begin
              sar_code = code_q & ~sar_bit_q;
            end
            if (sar_bit_q[0]) begin
              code_d   = sar_code;
              result_d = sar_code;
              done_d   = 1'b1;
              state_d  = StIdle;
            end else begin
              sar_bit_d = sar_bit_q >> 1;
              code_d    = sar_code | (sar_bit_q >> 1);
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      cnt_q      <= '0;
      code_q     <= '0;
      dir_up_q   <= 1'b1;
      sar_bit_q  <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      cmp_meta_q <= 1'b0;
      cmp_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      dir_up_q   <= dir_up_d;
      sar_bit_q  <= sar_bit_d;
      result_q   <= result_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      cmp_meta_q <= i_cmp;
      cmp_sync_q <= cmp_meta_q;
    end
  end

  assign o_dac_data   = code_q;
  assign o_busy       = (state_q != StIdle);
  assign o_dac_enable = (state_q != StIdle);
  assign o_done       = done_q;
  assign o_wrap       = wrap_q;
  assign o_result     = result_q;

endmodule

// File: tb/tb_vdac_seq_ctrl.sv
// Directed bench for vdac_seq_ctrl: reset, static, sawtooth, triangle, SAR and abort cases.
module tb_vdac_seq_ctrl;

  localparam int BW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [BW-1:0] code = '0;
  logic [DW-1:0] div = '0;
  logic [BW-1:0] thr = '0;
  logic          cmp;
  logic [BW-1:0] dac_data;
  logic          dac_enable;
  logic          busy;
  logic          done;
  logic          wrap;
  logic [BW-1:0] result;

  int checks = 0;
  int errors = 0;

  // Comparator model: output high while the DAC sits above the threshold.
  assign cmp = (dac_data > thr);

  vdac_seq_ctrl #(.BITWIDTH(BW), .DIVW(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_mode      (mode),
    .i_code      (code),
    .i_div       (div),
    .i_cmp       (cmp),
    .o_dac_data  (dac_data),
    .o_dac_enable(dac_enable),
    .o_busy      (busy),
    .o_done      (done),
    .o_wrap      (wrap),
    .o_result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_code(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [DW-1:0] d);
    mode  = m;
    div   = d;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic abort_run();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!done && n < 40);
  endtask

  initial begin
    int wraps;
    int first_wrap;
    int s;
    int expc;
    int n;

    // Reset state
    #12;
    chk_code("rst_data", dac_data, 6'd0);
    chk_bit("rst_en", dac_enable, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_wrap", wrap, 1'b0);
    chk_code("rst_result", result, 6'd0);
    rst_n = 1'b1;
    step(1);

    // Static mode, i_div=3: new code lands on the 4th edge after start
    code = 6'd21;
    launch(2'd0, 8'd3);
    chk_code("static_entry", dac_data, 6'd21);
    chk_bit("static_en", dac_enable, 1'b1);
    chk_bit("static_busy", busy, 1'b1);
    code = 6'd40;
    step(3);
    chk_code("static_hold", dac_data, 6'd21);
    step(1);
    chk_code("static_tick", dac_data, 6'd40);
    abort_run();
    chk_bit("static_stop_busy", busy, 1'b0);
    chk_bit("static_stop_en", dac_enable, 1'b0);
    chk_code("static_stop_data", dac_data, 6'd40);

    // Sawtooth, i_div=0
    launch(2'd1, 8'd0);
    chk_code("saw_start", dac_data, 6'd0);
    chk_bit("saw_start_wrap", wrap, 1'b0);
    wraps = 0;
    for (int k = 1; k <= 128; k++) begin
      step(1);
      chk_code("saw_code", dac_data, BW'(k % 64));
      chk_bit("saw_wrap", wrap, (k % 64) == 0);
      if (wrap) wraps++;
    end
    chk_int("saw_wrap_count", wraps, 2);
    abort_run();

    // Triangle, i_div=1: code held two cycles, period 252
    launch(2'd2, 8'd1);
    chk_code("tri_start", dac_data, 6'd0);
    wraps = 0;
    first_wrap = -1;
    for (int k = 1; k <= 260; k++) begin
      step(1);
      s = (k / 2) % 126;
      expc = (s <= 63) ? s : 126 - s;
      chk_code("tri_code", dac_data, BW'(expc));
      chk_bit("tri_wrap", wrap, (k % 2 == 0) && (k >= 2) && (s == 0));
      if (wrap) begin
        wraps++;
        if (first_wrap < 0) first_wrap = k;
      end
    end
    chk_int("tri_wrap_edge", first_wrap, 252);
    chk_int("tri_wrap_count", wraps, 1);
    abort_run();

    // SAR threshold 37
    thr = 6'd37;
    launch(2'd3, 8'd0);
    chk_code("sar37_msb", dac_data, 6'd32);
    chk_bit("sar37_busy", busy, 1'b1);
    wait_done(n);
    chk_int("sar37_latency", n, 18);
    chk_bit("sar37_done", done, 1'b1);
    chk_code("sar37_result", result, 6'd37);
    chk_code("sar37_data", dac_data, 6'd37);
    chk_bit("sar37_busy_end", busy, 1'b0);
    chk_bit("sar37_en_end", dac_enable, 1'b0);

    // Restart in the done cycle, threshold 0
    thr = 6'd0;
    launch(2'd3, 8'd0);
    chk_bit("sar0_accept", busy, 1'b1);
    chk_bit("sar0_done_pulse", done, 1'b0);
    chk_code("sar0_msb", dac_data, 6'd32);
    wait_done(n);
    chk_int("sar0_latency", n, 18);
    chk_code("sar0_result", result, 6'd0);

    // Threshold 63
    thr = 6'd63;
    step(1);
    launch(2'd3, 8'd0);
    wait_done(n);
    chk_int("sar63_latency", n, 18);
    chk_code("sar63_result", result, 6'd63);
    chk_code("sar63_data", dac_data, 6'd63);

    // Abort during SAR trial 3
    thr = 6'd37;
    step(1);
    launch(2'd3, 8'd0);
    step(6);
    chk_code("abort_trial3_code", dac_data, 6'd40);
    step(1);
    abort_run();
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_en", dac_enable, 1'b0);
    chk_code("abort_data", dac_data, 6'd40);
    chk_code("abort_result", result, 6'd63);
    wraps = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) wraps++;
      step(1);
    end
    chk_int("abort_no_done", wraps, 0);
    chk_code("abort_result_after", result, 6'd63);

    // Start and stop together in idle
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    chk_bit("startstop_busy", busy, 1'b0);
    chk_bit("startstop_en", dac_enable, 1'b0);

    // Start while busy is ignored
    launch(2'd1, 8'd0);
    step(3);
    chk_code("busy_pre", dac_data, 6'd3);
    mode  = 2'd3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk_code("busy_start_ignored", dac_data, 6'd4);
    chk_bit("busy_still", busy, 1'b1);
    step(1);
    chk_code("busy_mode_ignored", dac_data, 6'd5);

    // Asynchronous reset mid-ramp
    step(10);
    chk_code("pre_reset_data", dac_data, 6'd15);
    #2;
    rst_n = 1'b0;
    #1;
    chk_code("async_rst_data", dac_data, 6'd0);
    chk_bit("async_rst_en", dac_enable, 1'b0);
    chk_bit("async_rst_busy", busy, 1'b0);
    chk_bit("async_rst_done", done, 1'b0);
    chk_bit("async_rst_wrap", wrap, 1'b0);
    chk_code("async_rst_result", result, 6'd0);
    #1;
    rst_n = 1'b1;
    step(1);
    chk_bit("post_rst_busy", busy, 1'b0);
    chk_code("post_rst_data", dac_data, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
